// File: rtl/apb_arb_mux.sv
// Round-robin APB arbiter: several upstream initiators share one downstream APB port.
// Request fields are captured at grant; the block then runs its own SETUP/ACCESS sequence.
package apb_arb_mux_pkg;

    typedef struct packed {
        logic [31:0] paddr;
        logic        psel;
        logic        penable;
        logic        pwrite;
        logic [31:0] pwdata;
        logic [3:0]  pstrb;
    } apb_req_t;

    typedef struct packed {
        logic        pready;
        logic [31:0] prdata;
        logic        pslverr;
    } apb_resp_t;

endpackage

module apb_arb_mux #(
    parameter int unsigned NoSlvPorts = 2,
    parameter type         req_t      = apb_arb_mux_pkg::apb_req_t,
    parameter type         resp_t     = apb_arb_mux_pkg::apb_resp_t,
    parameter int unsigned IdxWidth   = (NoSlvPorts > 1) ? $clog2(NoSlvPorts) : 1
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  req_t                slv_req_i  [NoSlvPorts],
    output resp_t               slv_resp_o [NoSlvPorts],
    output req_t                mst_req_o,
    input  resp_t               mst_resp_i,
    output logic [IdxWidth-1:0] grant_o,
    output logic                busy_o
);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS
    } state_e;

    state_e              state_q;
    state_e              state_d;
    logic [IdxWidth-1:0] rr_q;
    logic [IdxWidth-1:0] rr_next;
    logic [IdxWidth-1:0] grant_q;
    logic [IdxWidth-1:0] pick_idx;
    logic                pick_valid;
    req_t                req_q;

    // Scan from rr_q upward with wrap; first requester wins.
    always_comb begin : arbitrate
        int unsigned cand;
        cand       = 0;
        pick_valid = 1'b0;
        pick_idx   = '0;
        for (int unsigned off = 0; off < NoSlvPorts; off++) begin
            cand = (32'(rr_q) + off) % NoSlvPorts;
            if (!pick_valid && slv_req_i[IdxWidth'(cand)].psel) begin
                pick_valid = 1'b1;
                pick_idx   = IdxWidth'(cand);
            end
        end
        rr_next = IdxWidth'((32'(pick_idx) + 32'd1) % NoSlvPorts);
    end

    always_ff @(posedge clk_i) begin : state_reg
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin : next_state
        state_d = state_q;
        case (state_q)
            IDLE:    if (pick_valid) state_d = SETUP;
            SETUP:   state_d = ACCESS;
            ACCESS:  if (mst_resp_i.pready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin : capture_reg
        if (rst_i) begin
            rr_q    <= '0;
            grant_q <= '0;
            req_q   <= '0;
        end else if (state_q == IDLE && pick_valid) begin
            rr_q    <= rr_next;
            grant_q <= pick_idx;
            req_q   <= slv_req_i[pick_idx];
        end
    end

    // Only the granted port sees the response, and only on the completing ACCESS cycle.
    always_comb begin : outputs
        mst_req_o         = req_q;
        mst_req_o.psel    = (state_q != IDLE);
        mst_req_o.penable = (state_q == ACCESS);
        for (int unsigned j = 0; j < NoSlvPorts; j++) begin
            slv_resp_o[j] = '0;
        end
        if (state_q == ACCESS && mst_resp_i.pready) begin
            slv_resp_o[grant_q] = mst_resp_i;
        end
        busy_o  = (state_q != IDLE);
        grant_o = grant_q;
    end

endmodule

// File: tb/tb_apb_arb_mux.sv
// Bench for apb_arb_mux: transaction-level model checked every cycle, directed
// literal scenarios, and a randomized phase; a single-port build is exercised too.
module tb_apb_arb_mux;
    import apb_arb_mux_pkg::*;

    logic      clk = 1'b0;
    logic      rst;
    apb_req_t  slv_req  [2];
    apb_resp_t slv_resp [2];
    apb_req_t  mst_req;
    apb_resp_t mst_resp;
    logic      grant;
    logic      busy;

    apb_req_t  slv_req1  [1];
    apb_resp_t slv_resp1 [1];
    apb_req_t  mst_req1;
    apb_resp_t mst_resp1;
    logic      grant1;
    logic      busy1;

    int vectors    = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    apb_arb_mux #(.NoSlvPorts(2)) dut (
        .clk_i(clk), .rst_i(rst),
        .slv_req_i(slv_req), .slv_resp_o(slv_resp),
        .mst_req_o(mst_req), .mst_resp_i(mst_resp),
        .grant_o(grant), .busy_o(busy)
    );

    apb_arb_mux #(.NoSlvPorts(1)) dut1 (
        .clk_i(clk), .rst_i(rst),
        .slv_req_i(slv_req1), .slv_resp_o(slv_resp1),
        .mst_req_o(mst_req1), .mst_resp_i(mst_resp1),
        .grant_o(grant1), .busy_o(busy1)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: one outstanding transfer with an age count since grant.
    bit       m_on    = 1'b0;
    bit       m_valid = 1'b0;
    int       m_port  = 0;
    int       m_age   = 0;
    int       m_rr    = 0;
    apb_req_t m_lat;
    int       m_log[$];

    always @(posedge clk) begin : model
        int p;
        if (rst) begin
            m_on    = 1'b1;
            m_valid = 1'b0;
            m_rr    = 0;
        end else if (m_valid) begin
            if (m_age >= 1 && mst_resp.pready) begin
                m_valid = 1'b0;
                m_log.push_back(m_port);
            end else begin
                m_age++;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                p = (m_rr + k) % 2;
                if (!m_valid && slv_req[p].psel) begin
                    m_valid = 1'b1;
                    m_port  = p;
                    m_age   = 0;
                    m_lat   = slv_req[p];
                    m_rr    = (p + 1) % 2;
                end
            end
        end
    end

    always @(negedge clk) begin : compare
        apb_resp_t exp_r;
        if (m_on) begin
            chk("busy", 64'(busy), 64'(m_valid));
            chk("psel", 64'(mst_req.psel), 64'(m_valid));
            chk("penable", 64'(mst_req.penable), 64'(m_valid && m_age >= 1));
            if (m_valid) begin
                chk("grant", 64'(grant), 64'(m_port));
                chk("paddr", 64'(mst_req.paddr), 64'(m_lat.paddr));
                chk("pwrite", 64'(mst_req.pwrite), 64'(m_lat.pwrite));
                chk("pwdata", 64'(mst_req.pwdata), 64'(m_lat.pwdata));
                chk("pstrb", 64'(mst_req.pstrb), 64'(m_lat.pstrb));
            end
            for (int j = 0; j < 2; j++) begin
                exp_r = (m_valid && m_age >= 1 && mst_resp.pready && m_port == j) ? mst_resp : '0;
                chk("slv_resp", 64'(slv_resp[j]), 64'(exp_r));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic neg();
        @(negedge clk);
    endtask

    task automatic idle_all();
        slv_req[0]  = '0;
        slv_req[1]  = '0;
        slv_req1[0] = '0;
    endtask

    initial begin : stimulus
        int        got[$];
        int        n_rdy;
        apb_resp_t e3;
        apb_resp_t exp6;

        rst       = 1'b1;
        idle_all();
        mst_resp  = '0;
        mst_resp1 = '0;
        repeat (3) tick();

        neg();
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_psel", 64'(mst_req.psel), 64'(0));
        chk("rst_penable", 64'(mst_req.penable), 64'(0));
        chk("rst_grant", 64'(grant), 64'(0));
        chk("rst_resp0", 64'(slv_resp[0]), 64'(0));
        chk("rst_resp1", 64'(slv_resp[1]), 64'(0));
        tick();
        rst = 1'b0;
        mst_resp.pready = 1'b1;

        // single write on port 0, zero-wait downstream
        slv_req[0] = '{paddr:32'h10, psel:1'b1, penable:1'b0, pwrite:1'b1,
                       pwdata:32'hA5A5A5A5, pstrb:4'hF};
        neg();
        chk("t1_idle_busy", 64'(busy), 64'(0));
        tick();
        slv_req[0].penable = 1'b1;
        neg();
        chk("t1_setup_psel", 64'(mst_req.psel), 64'(1));
        chk("t1_setup_penable", 64'(mst_req.penable), 64'(0));
        chk("t1_setup_paddr", 64'(mst_req.paddr), 64'h10);
        chk("t1_setup_pwdata", 64'(mst_req.pwdata), 64'hA5A5A5A5);
        chk("t1_setup_grant", 64'(grant), 64'(0));
        tick();
        neg();
        chk("t1_access_penable", 64'(mst_req.penable), 64'(1));
        chk("t1_pready0", 64'(slv_resp[0].pready), 64'(1));
        chk("t1_resp1", 64'(slv_resp[1]), 64'(0));
        tick();
        idle_all();
        neg();
        chk("t1_done_psel", 64'(mst_req.psel), 64'(0));
        chk("t1_done_busy", 64'(busy), 64'(0));

        // simultaneous requests after reset, both held
        rst = 1'b1;
        tick();
        rst = 1'b0;
        m_log.delete();
        slv_req[0] = '{paddr:32'h100, psel:1'b1, penable:1'b0, pwrite:1'b0, pwdata:32'h0, pstrb:4'h0};
        slv_req[1] = '{paddr:32'h200, psel:1'b1, penable:1'b0, pwrite:1'b1, pwdata:32'h1, pstrb:4'h3};
        for (int c = 0; c < 30; c++) begin
            neg();
            if (mst_req.psel && mst_req.penable && mst_resp.pready) got.push_back(int'(grant));
            if (got.size() == 4) break;
            tick();
        end
        tick();
        idle_all();
        chk("t2_count", 64'(got.size()), 64'(4));
        chk("t2_model_count", 64'(m_log.size()), 64'(4));
        for (int i = 0; i < 4; i++) begin
            if (i < got.size()) chk("t2_order", 64'(got[i]), 64'(i % 2));
            if (i < m_log.size()) chk("t2_model_order", 64'(m_log[i]), 64'(i % 2));
        end
        tick();

        // read on port 1 with three wait states and an error response
        mst_resp   = '0;
        slv_req[1] = '{paddr:32'h44, psel:1'b1, penable:1'b0, pwrite:1'b0, pwdata:32'h0, pstrb:4'h0};
        tick();
        tick();
        neg();
        chk("t3_wait1", 64'(slv_resp[1].pready), 64'(0));
        tick();
        tick();
        neg();
        chk("t3_wait3", 64'(slv_resp[1].pready), 64'(0));
        chk("t3_wait3_penable", 64'(mst_req.penable), 64'(1));
        tick();
        e3 = '{pready:1'b1, prdata:32'hDEADBEEF, pslverr:1'b1};
        mst_resp = e3;
        neg();
        chk("t3_resp1", 64'(slv_resp[1]), 64'(e3));
        chk("t3_resp0", 64'(slv_resp[0]), 64'(0));
        tick();
        idle_all();
        mst_resp = '0;

        // upstream changes after grant are ignored
        slv_req[0] = '{paddr:32'h10, psel:1'b1, penable:1'b0, pwrite:1'b1, pwdata:32'h5, pstrb:4'h1};
        tick();
        tick();
        slv_req[0].paddr = 32'h20;
        slv_req[0].psel  = 1'b0;
        neg();
        chk("t4_paddr_held", 64'(mst_req.paddr), 64'h10);
        chk("t4_psel_held", 64'(mst_req.psel), 64'(1));
        tick();
        mst_resp.pready = 1'b1;
        neg();
        chk("t4_paddr_end", 64'(mst_req.paddr), 64'h10);
        chk("t4_pready0", 64'(slv_resp[0].pready), 64'(1));
        tick();
        idle_all();
        mst_resp = '0;
        tick();

        // reset during ACCESS abandons the transfer and restarts round-robin
        slv_req[0] = '{paddr:32'h30, psel:1'b1, penable:1'b0, pwrite:1'b0, pwdata:32'h0, pstrb:4'h0};
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        idle_all();
        mst_resp.pready = 1'b1;
        neg();
        chk("t5_psel", 64'(mst_req.psel), 64'(0));
        chk("t5_busy", 64'(busy), 64'(0));
        chk("t5_pready0", 64'(slv_resp[0].pready), 64'(0));
        chk("t5_pready1", 64'(slv_resp[1].pready), 64'(0));
        slv_req[0] = '{paddr:32'h40, psel:1'b1, penable:1'b0, pwrite:1'b0, pwdata:32'h0, pstrb:4'h0};
        slv_req[1] = '{paddr:32'h50, psel:1'b1, penable:1'b0, pwrite:1'b0, pwdata:32'h0, pstrb:4'h0};
        tick();
        neg();
        chk("t5_grant", 64'(grant), 64'(0));
        chk("t5_paddr", 64'(mst_req.paddr), 64'h40);
        tick();
        idle_all();
        tick();
        mst_resp = '0;

        // single-port build: four back-to-back reads, prdata passes through
        mst_resp1.pready = 1'b1;
        slv_req1[0] = '{paddr:32'h8, psel:1'b1, penable:1'b0, pwrite:1'b0, pwdata:32'h0, pstrb:4'h0};
        n_rdy = 0;
        for (int k = 0; k < 12; k++) begin
            mst_resp1.prdata  = $urandom;
            mst_resp1.pslverr = 1'($urandom_range(0, 1));
            neg();
            chk("t6_psel", 64'(mst_req1.psel), 64'((k % 3) != 0));
            chk("t6_busy", 64'(busy1), 64'((k % 3) != 0));
            exp6 = ((k % 3) == 2) ? mst_resp1 : '0;
            chk("t6_resp", 64'(slv_resp1[0]), 64'(exp6));
            if ((k % 3) != 0) chk("t6_grant", 64'(grant1), 64'(0));
            if (slv_resp1[0].pready) n_rdy++;
            tick();
        end
        idle_all();
        chk("t6_count", 64'(n_rdy), 64'(4));

        // randomized phase, checked by the model every cycle
        for (int c = 0; c < 3000; c++) begin
            for (int p = 0; p < 2; p++) begin
                slv_req[p].psel    = 1'($urandom_range(0, 99) < 60);
                slv_req[p].penable = 1'($urandom_range(0, 1));
                slv_req[p].pwrite  = 1'($urandom_range(0, 1));
                slv_req[p].paddr   = $urandom;
                slv_req[p].pwdata  = $urandom;
                slv_req[p].pstrb   = 4'($urandom);
            end
            mst_resp.pready  = 1'($urandom_range(0, 1));
            mst_resp.prdata  = $urandom;
            mst_resp.pslverr = 1'($urandom_range(0, 1));
            rst = ($urandom_range(0, 199) == 0);
            tick();
        end
        rst = 1'b0;
        idle_all();
        tick();
        neg();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
